// File: rtl/row_pkg.sv
// Shared definitions for the row datapath: lane widths, row shape,
// serializer state encoding and the byte-rotation index helper.
package row_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_BYTES = 4;
  localparam int IDX_W     = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef logic [DATA_W-1:0]          byte_t;
  typedef byte_t [NUM_BYTES-1:0]      row_t;

  // Source lane for output lane k under a left rotation by rot.
  // The 2-bit add wraps naturally, giving (k + rot) mod 4.
  function automatic logic [IDX_W-1:0] rot_src(input logic [IDX_W-1:0] k,
                                               input logic [IDX_W-1:0] rot);
    return k + rot;
  endfunction

endpackage

// File: rtl/row_rotate.sv
// Combinational left byte-rotation of one row (ShiftRows-style).
// out[k] = in[(k + rot) mod 4]; rot = 0 is a pass-through.
module row_rotate
  import row_pkg::*;
#(
  parameter int DW = row_pkg::DATA_W
) (
  input  logic [NUM_BYTES-1:0][DW-1:0] row_i,
  input  logic [IDX_W-1:0]             rot_i,
  output logic [NUM_BYTES-1:0][DW-1:0] row_o
);

  // Select each output lane from its rotated source lane.
  always_comb begin
    row_o = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      row_o[k] = row_i[rot_src(IDX_W'(k), rot_i)];
    end
  end

endmodule

// File: rtl/row_serializer.sv
// Row-to-byte serializer: captures a 4-byte row (optionally rotated) over a
// valid/ready handshake and streams it out one byte per beat with index and
// last flags. in_ready looks through out_ready on the final byte so rows can
// follow each other with no idle cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no row held; ready to capture, output stream idle
// SEND  | row held in buffer; byte buf[idx] presented on the output
module row_serializer
  import row_pkg::*;
#(
  parameter int DATA_W    = row_pkg::DATA_W,
  parameter int NUM_BYTES = row_pkg::NUM_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [1:0]        rot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  state_e                            state_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [IDX_W-1:0]                  idx_d;
  logic [NUM_BYTES-1:0][DATA_W-1:0]  buf_q;
  logic [DATA_W-1:0]                 out_data_q;
  logic                              out_last_q;

  logic [NUM_BYTES-1:0][DATA_W-1:0]  in_row;
  logic [NUM_BYTES-1:0][DATA_W-1:0]  rot_row;
  logic                              capture;
  logic                              beat;

  assign in_row = {in3, in2, in1, in0};

  row_rotate #(
    .DW (DATA_W)
  ) u_rotate (
    .row_i (in_row),
    .rot_i (rot),
    .row_o (rot_row)
  );

  // Handshake qualifiers; in_ready opens on the last beat so a waiting row
  // is taken in the same cycle the current one finishes.
  always_comb begin
    out_valid = (state_q == SEND);
    in_ready  = (state_q == IDLE) | ((state_q == SEND) & out_last_q & out_ready);
    beat      = out_valid & out_ready;
    capture   = in_valid & in_ready;
    idx_d     = idx_q + 1'b1;
  end

  // Serializer FSM with registered byte/last outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else if (capture) begin
      // New row: covers both the idle case and the chained last-beat case.
      state_q    <= SEND;
      buf_q      <= rot_row;
      idx_q      <= '0;
      out_data_q <= rot_row[0];
      out_last_q <= 1'b0;
    end else if (beat) begin
      if (out_last_q) begin
        state_q    <= IDLE;
        idx_q      <= '0;
        out_last_q <= 1'b0;
      end else begin
        idx_q      <= idx_d;
        out_data_q <= buf_q[idx_d];
        out_last_q <= (idx_d == LAST_IDX);
      end
    end
  end

  assign out_data = out_data_q;
  assign out_idx  = idx_q;
  assign out_last = out_last_q;
  assign busy     = (state_q == SEND);

endmodule

// File: tb/tb_row_serializer.sv
// Bench for row_serializer: a queue-of-pending-bytes model checked every
// cycle, plus literal checks on the emitted byte stream per scenario.
module tb_row_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_row [4];
  logic [1:0] rot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;
  logic       busy;

  always #5 clock = ~clock;

  row_serializer dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in_row[0]),
    .in1       (in_row[1]),
    .in2       (in_row[2]),
    .in3       (in_row[3]),
    .rot       (rot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] i;
  } mbyte_t;

  mbyte_t     mq[$];
  logic [7:0] log_q[$];
  int         beat_cyc[$];
  int         cyc = 0;
  int         acc_cnt = 0;
  int         total = 0;
  int         bad = 0;
  logic       checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (mq.size() == 0) || (mq.size() == 1 && out_ready);
  endfunction

  // Model: pending bytes of the held rows; a beat pops one, an accepted row
  // pushes its four rotated bytes.
  always @(posedge clock or posedge reset) begin
    logic acc;
    if (reset) begin
      mq.delete();
    end else begin
      cyc++;
      acc = in_valid && model_ready();
      if (out_valid && out_ready) begin
        log_q.push_back(out_data);
        beat_cyc.push_back(cyc);
      end
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        acc_cnt++;
        for (int k = 0; k < 4; k++) begin
          mbyte_t b;
          b.d = in_row[(k + int'(rot)) % 4];
          b.i = 2'(k);
          mq.push_back(b);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (checking && !reset) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("out_data", {24'd0, out_data}, {24'd0, mq[0].d});
        chk("out_idx", {30'd0, out_idx}, {30'd0, mq[0].i});
        chk("out_last", {31'd0, out_last}, {31'd0, mq[0].i == 2'd3});
      end
    end
  end

  task automatic send_row(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input logic [1:0] r);
    int start;
    bit ok;
    in_row[0] = b0; in_row[1] = b1; in_row[2] = b2; in_row[3] = b3;
    rot = r;
    in_valid = 1'b1;
    start = acc_cnt;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (acc_cnt != start) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: row %0h not taken within 40 cycles", b0);
    end
    in_valid = 1'b0;
    rot = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (mq.size() == 0) break;
      @(posedge clock); #1;
    end
    if (mq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d bytes still pending", mq.size());
    end
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, log_q.size(), exp.size());
    for (int k = 0; k < exp.size() && k < log_q.size(); k++)
      chk(name, {24'd0, log_q[k]}, {24'd0, exp[k]});
  endtask

  initial begin
    logic [7:0] e[$];
    reset = 1'b1;
    in_valid = 1'b0;
    in_row[0] = '0; in_row[1] = '0; in_row[2] = '0; in_row[3] = '0;
    rot = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checking = 1'b1;
    @(posedge clock); #1;

    // Single row, no rotation; first byte one cycle after capture.
    log_q.delete();
    send_row(8'h11, 8'h22, 8'h33, 8'h44, 2'd0);
    @(negedge clock);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {24'd0, out_data}, 32'h11);
    drain();
    @(negedge clock);
    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("done_out_valid", {31'd0, out_valid}, 32'd0);
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_log("row1", e);
    @(posedge clock); #1;

    // Rotations.
    log_q.delete();
    send_row(8'hA0, 8'hA1, 8'hA2, 8'hA3, 2'd1);
    drain();
    e = '{8'hA1, 8'hA2, 8'hA3, 8'hA0};
    check_log("rot1", e);
    log_q.delete();
    send_row(8'hA0, 8'hA1, 8'hA2, 8'hA3, 2'd3);
    drain();
    e = '{8'hA3, 8'hA0, 8'hA1, 8'hA2};
    check_log("rot3", e);

    // Back-pressure on idx 2 for three cycles.
    log_q.delete();
    send_row(8'h01, 8'h02, 8'h03, 8'h04, 2'd0);
    repeat (2) begin @(posedge clock); #1; end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      chk("stall_idx", {30'd0, out_idx}, 32'd2);
      chk("stall_data", {24'd0, out_data}, 32'h03);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    drain();
    e = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_log("stall", e);

    // Back-to-back rows with no bubble.
    log_q.delete();
    beat_cyc.delete();
    send_row(8'h11, 8'h22, 8'h33, 8'h44, 2'd0);
    send_row(8'h55, 8'h66, 8'h77, 8'h88, 2'd0);
    drain();
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_log("b2b", e);
    if (beat_cyc.size() == 8)
      chk("b2b_span", beat_cyc[7] - beat_cyc[0], 32'd7);
    else
      chk("b2b_beats", beat_cyc.size(), 32'd8);

    // Reset in the middle of a row.
    send_row(8'h90, 8'h91, 8'h92, 8'h93, 2'd0);
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("postrst_valid", {31'd0, out_valid}, 32'd0);
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    log_q.delete();
    send_row(8'hC0, 8'hC1, 8'hC2, 8'hC3, 2'd0);
    drain();
    e = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    check_log("postrst", e);

    // Offer while not ready is ignored.
    log_q.delete();
    send_row(8'h10, 8'h11, 8'h12, 8'h13, 2'd0);
    in_row[0] = 8'hFF; in_row[1] = 8'hFF; in_row[2] = 8'hFF; in_row[3] = 8'hFF;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    drain();
    repeat (3) begin @(posedge clock); #1; end
    e = '{8'h10, 8'h11, 8'h12, 8'h13};
    check_log("ignored", e);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/row_serializer.md
Name: row_serializer

Overview:
- Transmit-side counterpart to the 4-byte row register.
- Accepts one full row (4 bytes, parallel) through a valid/ready handshake, with an optional left byte-rotation (ShiftRows-style) applied at capture.
- Emits the row one byte per beat on a byte stream with valid/ready and last flags.
- Sits between the row-parallel datapath and the byte-wide output/UART/display path.

Parameters:
- DATA_W, 8, width of one byte lane.
- NUM_BYTES, 4, bytes per row. Fixed at 4 for this revision; rot and idx widths derive from it.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  row offered on in0..in3.
- in_ready  out  1  block can accept a row this cycle.
- in0  in  DATA_W  row byte 0.
- in1  in  DATA_W  row byte 1.
- in2  in  DATA_W  row byte 2.
- in3  in  DATA_W  row byte 3.
- rot  in  2  left-rotate amount, sampled with the row.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  DATA_W  current byte.
- out_idx  out  2  position of current byte within the row (0..3).
- out_last  out  1  current byte is position 3.
- busy  out  1  a row is held (state SEND).

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, idx=0, row buffer=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
  - in_ready=1 once reset is released.
  - Reset asserted mid-row discards the row immediately; no partial byte is emitted afterwards.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1, busy=1.
- Capture (in_valid & in_ready):
  - buf[k] <= in[(k+rot) mod 4] for k=0..3. Example: rot=1 stores {in1,in2,in3,in0} as buf0..3.
  - idx <= 0; state <= SEND.
  - Latency: first byte is valid on the cycle after capture.
- Output:
  - out_data = buf[idx]; out_idx = idx; out_last = (idx==3).
  - All outputs hold stable while out_valid & !out_ready (no change under stall).
- Beat (out_valid & out_ready):
  - If idx<3: idx <= idx+1.
  - If idx==3: the row is complete.
    - If in_valid, capture the next row the same cycle; state stays SEND with idx=0.
    - Otherwise return to IDLE.
- in_ready = (state==IDLE) | (state==SEND & idx==3 & out_ready). This is combinational from out_ready and enables back-to-back rows with no bubble. Sustained throughput is 1 byte/cycle.
- in_valid while in_ready=0 is ignored. The upstream must hold the row until it is accepted; no capture occurs.
- rot is sampled only at capture. Changes during SEND have no effect.
- out_valid never drops without a beat, except on reset.

Decomposition:
- Shared package (row_pkg): DATA_W, NUM_BYTES, IDX_W=2, state encoding (IDLE=0, SEND=1), row type as a 4x DATA_W array.
- One natural combinational sub-module: row_rotate (4 bytes in, rot in, 4 bytes out). It is reusable by ShiftRows logic elsewhere.

Test Plan:
- Reset then one row: in0..3=11,22,33,44, rot=0, out_ready=1 -> bytes 11,22,33,44 on 4 consecutive cycles starting 1 cycle after capture; out_last only on 44; then in_ready=1 and out_valid=0.
- Rotation: in0..3=A0,A1,A2,A3 with rot=1 -> A1,A2,A3,A0. With rot=3 -> A3,A0,A1,A2.
- Back-pressure: out_ready low for 3 cycles on idx=2 -> out_data and out_idx held at 2 and out_valid held high; the sequence resumes unchanged, with no duplicate or lost byte.
- Back-to-back: second row 55,66,77,88 held valid during the first row -> captured on the last beat of the first row; 8 consecutive beats with no bubble; in_ready=0 during idx 0..2.
- Reset mid-row: assert reset after byte 1 is accepted -> out_valid=0 and in_ready=1 after release; a new row C0..C3 emits C0 first, with no leftover bytes.
- Ignored offer: in_valid pulsed while in_ready=0 with row FF,FF,FF,FF, then dropped -> no FF appears on out_data.
